// File: rtl/timer_pkg.sv
// Shared constants for the sequencing timer.
package timer_pkg;
    localparam int unsigned TIMER_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/timer.sv
// Restartable modulo-N cycle counter with a registered terminal-count flag.
// Counts 0..n_i-1 while start_i is high and is held at zero otherwise.
module timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] curr_time_q,
    output logic             curr_end_q
);

    logic [WIDTH-1:0] r_time;
    logic             r_end;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_nxt;
    logic             w_run;

    // n_i == 0 disables counting, so the all-ones value of n_i-1 is never used as a wrap point.
    assign w_run  = start_i && (n_i != '0);
    assign w_last = n_i - WIDTH'(1);

    always_comb begin
        w_nxt = '0;
        if (w_run && (r_time < w_last)) begin
            w_nxt = r_time + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time <= '0;
            r_end  <= 1'b0;
        end else begin
            r_time <= w_nxt;
            r_end  <= w_run && (w_nxt == w_last);
        end
    end

    assign curr_time_q = r_time;
    assign curr_end_q  = r_end;

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the timer: reset, idle, run, stop/restart,
// period shrink, degenerate periods and mid-run reset.
module tb_timer;
    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] n_i;
    logic             start_i;
    logic [WIDTH-1:0] curr_time_q;
    logic             curr_end_q;

    int checks = 0;
    int errors = 0;

    timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .n_i         (n_i),
        .start_i     (start_i),
        .curr_time_q (curr_time_q),
        .curr_end_q  (curr_end_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] t_exp, input logic e_exp);
        checks++;
        assert (curr_time_q === t_exp) else begin
            errors++;
            $error("FAIL %s curr_time_q got %0d expected %0d", tag, curr_time_q, t_exp);
        end
        checks++;
        assert (curr_end_q === e_exp) else begin
            errors++;
            $error("FAIL %s curr_end_q got %0b expected %0b", tag, curr_end_q, e_exp);
        end
        $display("%s: n_i=%0d start_i=%0b time=%0d end=%0b", tag, n_i, start_i, curr_time_q, curr_end_q);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        n_i     = 16'd20;

        // Reset and idle
        step();
        chk("reset", 16'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle", 16'd0, 1'b0);
        end

        // Run with n_i = 20 for 50 cycles: sample i reads i mod 20
        start_i = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step();
            chk("run20", WIDTH'(i % 20), (i % 20) == 19);
        end

        // Stop, switch to n_i = 8 and run to count 5
        start_i = 1'b0;
        step();
        chk("stop_pre8", 16'd0, 1'b0);
        n_i     = 16'd8;
        start_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("run8_to5", WIDTH'(i), 1'b0);
        end
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stopped", 16'd0, 1'b0);
        end
        start_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("restart8", WIDTH'(i % 8), (i % 8) == 7);
        end

        // Count is 1 here; go to n_i = 20 and run up to 12
        n_i = 16'd20;
        for (int i = 2; i <= 12; i++) begin
            step();
            chk("run20_to12", WIDTH'(i), 1'b0);
        end
        n_i = 16'd10;
        step();
        chk("shrink_wrap", 16'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("run10", WIDTH'(i % 10), (i % 10) == 9);
        end

        // Degenerate periods
        n_i = 16'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n1", 16'd0, 1'b1);
        end
        n_i = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n0", 16'd0, 1'b0);
        end

        // Synchronous reset mid-run
        n_i = 16'd20;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("run20_to7", WIDTH'(i), 1'b0);
        end
        rst = 1'b1;
        step();
        chk("midrun_reset", 16'd0, 1'b0);
        rst = 1'b0;
        step();
        chk("after_reset", 16'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
